// File: rtl/uc_gerencia_frame.sv
// Frame-level control unit: once per frame it sequences shot movement, asteroid movement and
// the shot/asteroid comparison, and accumulates the score. Optional timeout: UC_GERENCIA_FRAME_TIMEOUT_EN.
module uc_gerencia_frame #(
    parameter int TIMEOUT_CICLOS = 1023,
    parameter int LARGURA_PONTOS = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      iniciar,
    input  logic                      tick_frame,
    input  logic                      fim_movimenta_tiros,
    input  logic                      fim_movimenta_asteroides,
    input  logic                      s_fim_comparacao,
    input  logic                      asteroide_destruido,
    output logic                      movimenta_tiros,
    output logic                      movimenta_asteroides,
    output logic                      compara_tiros_e_asteroides,
    output logic                      fim_frame,
    output logic [LARGURA_PONTOS-1:0] pontuacao,
    output logic                      sobrecarga,
    output logic                      erro_timeout,
    output logic [4:0]                db_estado_gerencia_frame
);

    // Handshake: each sub-FSM gets a one-cycle start pulse from an inicia_* state; its done
    // pulse is only honoured in the matching espera_* state and is ignored anywhere else.
    typedef enum logic [4:0] {
        INICIO            = 5'h00,
        ESPERA_INICIO     = 5'h01,
        ESPERA_FRAME      = 5'h02,
        INICIA_TIROS      = 5'h03,
        ESPERA_TIROS      = 5'h04,
        INICIA_ASTEROIDES = 5'h05,
        ESPERA_ASTEROIDES = 5'h06,
        INICIA_COMPARACAO = 5'h07,
        ESPERA_COMPARACAO = 5'h08,
        FIM_FRAME         = 5'h09,
        ERRO              = 5'h0F
    } estado_t;

    estado_t                   estado;
    estado_t                   proximo;
    logic                      pendente;
    logic                      sobrecarga_r;
    logic                      asd_anterior;
    logic                      borda_destruido;
    logic                      inicia_jogo;
    logic                      tick_ocupado;
    logic                      tick_perdido;
    logic                      tempo_esgotado;
    logic [LARGURA_PONTOS-1:0] pontos;

    assign inicia_jogo     = (estado == ESPERA_INICIO) && iniciar;
    assign borda_destruido = asteroide_destruido && !asd_anterior;

    // A tick that arrives while a frame is busy is queued; a second one is lost.
    assign tick_ocupado = tick_frame &&
                          !(estado inside {ESPERA_FRAME, ESPERA_INICIO, ERRO});
    assign tick_perdido = tick_frame && pendente &&
                          !(estado inside {ESPERA_INICIO, ERRO});

`ifdef UC_GERENCIA_FRAME_TIMEOUT_EN
    localparam int LARGURA_CONT = (TIMEOUT_CICLOS < 2) ? 1 : $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [LARGURA_CONT-1:0] LIMITE_MENOS_UM = LARGURA_CONT'(TIMEOUT_CICLOS - 1);

    logic [LARGURA_CONT-1:0] contador;
    logic                    em_espera;
    logic                    erro_r;

    assign em_espera = estado inside {ESPERA_TIROS, ESPERA_ASTEROIDES, ESPERA_COMPARACAO};
    // The count reaches the limit at the end of this cycle; a done in the same cycle wins.
    assign tempo_esgotado = em_espera && (contador == LIMITE_MENOS_UM);

    always_ff @(posedge clock) begin
        if (reset) begin
            contador <= '0;
        end else if (em_espera) begin
            contador <= contador + LARGURA_CONT'(1);
        end else begin
            contador <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            erro_r <= 1'b0;
        end else if (proximo == ERRO) begin
            erro_r <= 1'b1;
        end
    end

    assign erro_timeout = erro_r;
`else
    assign tempo_esgotado = 1'b0;
    assign erro_timeout   = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIO;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = estado;
        case (estado)
            INICIO:            proximo = ESPERA_INICIO;
            ESPERA_INICIO:     if (iniciar) proximo = ESPERA_FRAME;
            ESPERA_FRAME:      if (tick_frame || pendente) proximo = INICIA_TIROS;
            INICIA_TIROS:      proximo = ESPERA_TIROS;
            ESPERA_TIROS: begin
                if (fim_movimenta_tiros)  proximo = INICIA_ASTEROIDES;
                else if (tempo_esgotado)  proximo = ERRO;
            end
            INICIA_ASTEROIDES: proximo = ESPERA_ASTEROIDES;
            ESPERA_ASTEROIDES: begin
                if (fim_movimenta_asteroides) proximo = INICIA_COMPARACAO;
                else if (tempo_esgotado)      proximo = ERRO;
            end
            INICIA_COMPARACAO: proximo = ESPERA_COMPARACAO;
            ESPERA_COMPARACAO: begin
                if (s_fim_comparacao)     proximo = FIM_FRAME;
                else if (tempo_esgotado)  proximo = ERRO;
            end
            FIM_FRAME:         proximo = ESPERA_FRAME;
            ERRO:              proximo = ERRO;
            default:           proximo = INICIO;
        endcase
    end

    always_comb begin
        movimenta_tiros            = 1'b0;
        movimenta_asteroides       = 1'b0;
        compara_tiros_e_asteroides = 1'b0;
        fim_frame                  = 1'b0;
        db_estado_gerencia_frame   = estado;
        case (estado)
            INICIA_TIROS:      movimenta_tiros            = 1'b1;
            INICIA_ASTEROIDES: movimenta_asteroides       = 1'b1;
            INICIA_COMPARACAO: compara_tiros_e_asteroides = 1'b1;
            FIM_FRAME:         fim_frame                  = 1'b1;
            default: ;
        endcase
    end

    // In espera_frame the queued tick is always consumed, since it forces the transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            pendente <= 1'b0;
        end else if (inicia_jogo || (estado == ESPERA_FRAME)) begin
            pendente <= 1'b0;
        end else if (tick_ocupado) begin
            pendente <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sobrecarga_r <= 1'b0;
        end else if (inicia_jogo) begin
            sobrecarga_r <= 1'b0;
        end else if (tick_perdido) begin
            sobrecarga_r <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            asd_anterior <= 1'b0;
        end else begin
            asd_anterior <= asteroide_destruido;
        end
    end

    // Score counts each destruction once (rising edge) and saturates instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            pontos <= '0;
        end else if (inicia_jogo) begin
            pontos <= '0;
        end else if (borda_destruido && (estado == ESPERA_COMPARACAO) && (pontos != '1)) begin
            pontos <= pontos + LARGURA_PONTOS'(1);
        end
    end

    assign pontuacao  = pontos;
    assign sobrecarga = sobrecarga_r;

endmodule

// File: doc/uc_gerencia_frame.md
# uc_gerencia_frame

Frame-level control unit that initiates, once per game frame, the three sub-FSM sequences: shot movement, asteroid movement, and the shot/asteroid comparison. It drives each sub-FSM's start pulse, waits for its done pulse, and accumulates the score from the `asteroide_destruido` indication issued during comparison. It sits above the comparison, movement and rendering control units in the AstroGenius UC hierarchy.

## Interface
**Parameters**
- `TIMEOUT_CICLOS`, default 1023: maximum wait cycles per phase before error (timeout build only).
- `LARGURA_PONTOS`, default 8: score width.

**Ports**
- `clock` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `iniciar` in 1: game start request.
- `tick_frame` in 1: one-cycle frame tick.
- `fim_movimenta_tiros` in 1: shot-movement done pulse.
- `fim_movimenta_asteroides` in 1: asteroid-movement done pulse.
- `s_fim_comparacao` in 1: comparison done pulse.
- `asteroide_destruido` in 1: high while the comparison unit destroys an asteroid (2 cycles per event).
- `movimenta_tiros` out 1: start pulse.
- `movimenta_asteroides` out 1: start pulse.
- `compara_tiros_e_asteroides` out 1: start pulse.
- `fim_frame` out 1: frame complete pulse.
- `pontuacao` out LARGURA_PONTOS: score, saturating.
- `sobrecarga` out 1: sticky flag, frame tick lost.
- `erro_timeout` out 1: sticky flag, sub-FSM unresponsive.
- `db_estado_gerencia_frame` out 5: debug state code.

## Operation
- Moore FSM. Codes: inicio 0, espera_inicio 1, espera_frame 2, inicia_tiros 3, espera_tiros 4, inicia_asteroides 5, espera_asteroides 6, inicia_comparacao 7, espera_comparacao 8, fim_frame 9, erro F. Unused codes → inicio.
- Transitions:
  - inicio → espera_inicio.
  - espera_inicio → espera_frame on `iniciar`; entering clears `pontuacao`, `sobrecarga` and `pendente`.
  - espera_frame → inicia_tiros on `tick_frame | pendente`, which also clears `pendente`.
  - inicia_tiros → espera_tiros.
  - espera_tiros → inicia_asteroides on `fim_movimenta_tiros`.
  - inicia_asteroides → espera_asteroides.
  - espera_asteroides → inicia_comparacao on `fim_movimenta_asteroides`.
  - inicia_comparacao → espera_comparacao.
  - espera_comparacao → fim_frame on `s_fim_comparacao`.
  - fim_frame → espera_frame.
  - erro stays in erro until reset.
- Start outputs are high only in their inicia_* state, giving exactly one-cycle pulses. `fim_frame` is high only in state fim_frame.
- Done inputs are sampled only in the matching espera_* state. Done in any other state is ignored.
- Frame ticks:
  - `tick_frame` in any state other than espera_frame/espera_inicio/erro sets one-deep `pendente`.
  - A tick while `pendente` is already 1 sets `sobrecarga`, which stays set until reset or the next `iniciar`.
- Score:
  - Edge detector on `asteroide_destruido` (registered previous value).
  - A 0→1 edge seen in espera_comparacao increments `pontuacao` by 1.
  - Saturates at 2^LARGURA_PONTOS−1; no wrap.
  - Edges outside espera_comparacao are ignored.
  - An edge coinciding with `s_fim_comparacao` is still counted.
- Reset values: state inicio; every output 0; `pendente` 0; previous `asteroide_destruido` register 0.
- Reset asserted mid-frame: next cycle is inicio, score cleared, no start pulse emitted.

## Timing
- Start pulse latency:
  - `tick_frame` high in espera_frame at edge N → `movimenta_tiros` high during cycle N+1.
  - Done sampled at edge M → next start pulse high during cycle M+1.
- Minimum frame with same-cycle-after-start done responses: tick → `fim_frame` = 7 cycles.
- Score updates on the clock edge after the detected rising edge, so it is visible one cycle later.
- All outputs registered state decodes; no combinational input→output paths.

## Configuration
- `UC_GERENCIA_FRAME_TIMEOUT_EN` defined:
  - A wait counter of ceil(log2(TIMEOUT_CICLOS+1)) bits clears on entry to each espera_* phase state (espera_tiros, espera_asteroides, espera_comparacao) and increments each cycle spent there.
  - Reaching TIMEOUT_CICLOS without done → erro, with `erro_timeout` = 1 (sticky).
  - A done arriving in the same cycle the count reaches TIMEOUT_CICLOS wins: normal transition, no error.
- Undefined: no counter; waits indefinitely; `erro_timeout` tied 0; erro unreachable.

## Test plan
- Reset, `iniciar`, tick, sub-FSM models answering done 1 cycle after start → start pulses in order tiros/asteroides/comparacao, each exactly 1 cycle; `fim_frame` 7 cycles after tick.
- Comparison model raising `asteroide_destruido` for 2 cycles, 3 times, in one frame → `pontuacao` = 3. Repeat with a level held across frames → no extra count.
- Preload score to 254, then 3 destructions → `pontuacao` = 255 (saturated).
- Two ticks during espera_asteroides → `pendente` set, `sobrecarga` = 1, second frame starts immediately after fim_frame.
- Timeout build, TIMEOUT_CICLOS = 15, no `fim_movimenta_tiros` → erro (db = 0xF) after 15 cycles in espera_tiros, `erro_timeout` = 1. Done on cycle 15 → no error.
- `reset` asserted in espera_comparacao with score 5 → next cycle: state 0, `pontuacao` 0, all pulses 0.
